// File: rtl/uc_multiciclo_ws_pkg.sv
// Shared encodings for the multicycle MIPS control unit with memory wait states.
// State codes are exported on the State debug port and must stay fixed.
package uc_pkg;

   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_LW_READ   = 4'd4,
      S_LW_WB     = 4'd5,
      S_SW_WRITE  = 4'd6,
      S_R_EXEC    = 4'd7,
      S_R_WB      = 4'd8,
      S_ADDI_EXEC = 4'd9,
      S_ADDI_WB   = 4'd10,
      S_BRANCH    = 4'd11,
      S_JUMP      = 4'd12,
      S_LUI_WB    = 4'd13,
      S_EXC_OPC   = 4'd14,
      S_EXC_OVF   = 4'd15
   } state_t;

   localparam int unsigned WAIT_CNT_W = 4;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;

   localparam logic [1:0] B_REG     = 2'b00;
   localparam logic [1:0] B_FOUR    = 2'b01;
   localparam logic [1:0] B_SEXT    = 2'b10;
   localparam logic [1:0] B_SEXT_SH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_EXC    = 2'b11;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_LUI    = 2'b10;

endpackage

// File: rtl/uc_multiciclo_ws_wait_counter.sv
// Memory wait-state counter: counts up while enabled, flags done at MEM_WAIT.
// Cleared by the control unit whenever the FSM changes state.
module uc_wait_counter
   import uc_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic done
);

   logic [WAIT_CNT_W-1:0] count_q, count_d;

   assign done = (count_q == WAIT_CNT_W'(MEM_WAIT));

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !done) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uc_multiciclo_ws.sv
// Multicycle MIPS control unit (Moore FSM) with memory wait states, addi and
// precise exceptions (overflow / invalid opcode) that save EPC and vector.
module uc_multiciclo_ws
   import uc_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 1,
   parameter int unsigned STATE_W  = 6,
   parameter bit          EXC_EN   = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [5:0]         OPcode,
   input  logic [5:0]         funct,
   input  logic               Overflow,
   output logic               EscreveMem,
   output logic               EscreveMDR,
   output logic               EscreveIR,
   output logic               EscrevePC,
   output logic               EscrevePCCondEQ,
   output logic               EscrevePCCondNE,
   output logic               EscreveAluOut,
   output logic               EscreveReg,
   output logic               EscreveEPC,
   output logic               IouD,
   output logic               RegDst,
   output logic               OrigAALU,
   output logic [1:0]         OrigBALU,
   output logic [2:0]         OpAlu,
   output logic [1:0]         MemparaReg,
   output logic [1:0]         OrigPC,
   output logic [STATE_W-1:0] State
);

   state_t state_q, state_d;
   logic   exc_phase_q, exc_phase_d;
   logic   wait_en;
   logic   wait_done;

   uc_wait_counter #(
      .MEM_WAIT(MEM_WAIT)
   ) u_wait (
      .clock (clock),
      .reset (reset),
      .clear (state_d != state_q),
      .enable(wait_en),
      .done  (wait_done)
   );

   assign State = STATE_W'(state_q);

   always_comb begin
      state_d         = state_q;
      exc_phase_d     = 1'b0;
      wait_en         = 1'b0;
      EscreveMem      = 1'b0;
      EscreveMDR      = 1'b0;
      EscreveIR       = 1'b0;
      EscrevePC       = 1'b0;
      EscrevePCCondEQ = 1'b0;
      EscrevePCCondNE = 1'b0;
      EscreveAluOut   = 1'b0;
      EscreveReg      = 1'b0;
      EscreveEPC      = 1'b0;
      IouD            = 1'b0;
      RegDst          = 1'b0;
      OrigAALU        = 1'b0;
      OrigBALU        = B_REG;
      OpAlu           = ALU_ADD;
      MemparaReg      = M2R_ALUOUT;
      OrigPC          = PC_ALU;

      case (state_q)
         S_RESET: state_d = S_FETCH;

         S_FETCH: begin
            wait_en = 1'b1;
            if (wait_done) begin
               EscreveIR = 1'b1;
               EscrevePC = 1'b1;
               OrigBALU  = B_FOUR;
               state_d   = S_DECODE;
            end
         end

         S_DECODE: begin
            OrigBALU      = B_SEXT_SH;
            EscreveAluOut = 1'b1;
            case (OPcode)
               OP_RTYPE:     state_d = S_R_EXEC;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_LUI:       state_d = S_LUI_WB;
               OP_ADDI:      state_d = S_ADDI_EXEC;
               default:      state_d = EXC_EN ? S_EXC_OPC : S_FETCH;
            endcase
         end

         S_MEM_ADDR: begin
            OrigAALU      = 1'b1;
            OrigBALU      = B_SEXT;
            EscreveAluOut = 1'b1;
            state_d       = (OPcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
         end

         S_LW_READ: begin
            IouD    = 1'b1;
            wait_en = 1'b1;
            if (wait_done) begin
               EscreveMDR = 1'b1;
               state_d    = S_LW_WB;
            end
         end

         S_LW_WB: begin
            MemparaReg = M2R_MDR;
            EscreveReg = 1'b1;
            state_d    = S_FETCH;
         end

         S_SW_WRITE: begin
            IouD       = 1'b1;
            EscreveMem = 1'b1;
            wait_en    = 1'b1;
            if (wait_done) state_d = S_FETCH;
         end

         S_R_EXEC: begin
            OrigAALU      = 1'b1;
            OpAlu         = ALU_FUNCT;
            EscreveAluOut = 1'b1;
            // Only signed add/sub trap; unsigned variants overflow silently.
            if (EXC_EN && Overflow && (funct == FN_ADD || funct == FN_SUB)) begin
               state_d = S_EXC_OVF;
            end else begin
               state_d = S_R_WB;
            end
         end

         S_R_WB: begin
            RegDst     = 1'b1;
            EscreveReg = 1'b1;
            state_d    = S_FETCH;
         end

         S_ADDI_EXEC: begin
            OrigAALU      = 1'b1;
            OrigBALU      = B_SEXT;
            EscreveAluOut = 1'b1;
            state_d       = (EXC_EN && Overflow) ? S_EXC_OVF : S_ADDI_WB;
         end

         S_ADDI_WB: begin
            EscreveReg = 1'b1;
            state_d    = S_FETCH;
         end

         S_BRANCH: begin
            OrigAALU        = 1'b1;
            OpAlu           = ALU_SUB;
            OrigPC          = PC_ALUOUT;
            EscrevePCCondEQ = (OPcode == OP_BEQ);
            EscrevePCCondNE = (OPcode == OP_BNE);
            state_d         = S_FETCH;
         end

         S_JUMP: begin
            OrigPC    = PC_JUMP;
            EscrevePC = 1'b1;
            state_d   = S_FETCH;
         end

         S_LUI_WB: begin
            MemparaReg = M2R_LUI;
            EscreveReg = 1'b1;
            state_d    = S_FETCH;
         end

         // Two-cycle trap: EPC <= PC-4 first, then load the vector into PC.
         S_EXC_OPC, S_EXC_OVF: begin
            if (!exc_phase_q) begin
               OrigBALU    = B_FOUR;
               OpAlu       = ALU_SUB;
               EscreveEPC  = 1'b1;
               exc_phase_d = 1'b1;
            end else begin
               OrigPC    = PC_EXC;
               EscrevePC = 1'b1;
               state_d   = S_FETCH;
            end
         end

         default: state_d = S_RESET;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= S_RESET;
         exc_phase_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         exc_phase_q <= exc_phase_d;
      end
   end

endmodule

// File: tb/tb_uc_multiciclo_ws.sv
// Bench for uc_multiciclo_ws: three parameterisations driven one at a time,
// checked cycle by cycle against an instruction-level trace model.
module tb_uc_multiciclo_ws;

   typedef struct packed {
      logic [5:0] st;
      logic       mem, mdr, ir, pc, ceq, cne, aout, rw, epc, iord, rdst, oa;
      logic [1:0] ob;
      logic [2:0] op;
      logic [1:0] m2r;
      logic [1:0] opc;
   } e_t;

   typedef struct {
      int         g;
      logic [5:0] op;
      logic [5:0] fn;
      logic       ov;
      int         cyc;
      int         epc;
      int         rw;
      int         ceq;
      int         cne;
   } vec_t;

   // g0: MEM_WAIT=2 EXC_EN=1, g1: MEM_WAIT=0 EXC_EN=1, g2: MEM_WAIT=3 EXC_EN=0
   localparam logic [11:0] MWS = {4'd3, 4'd0, 4'd2};
   localparam logic [2:0]  EES = 3'b011;

   logic            clk = 1'b0;
   logic [2:0]      rst_n = '0;
   logic [2:0][5:0] opc_in = '0;
   logic [2:0][5:0] fn_in = '0;
   logic [2:0]      ovf_in = '0;
   e_t   [2:0]      obs;

   int tests = 0;
   int fails = 0;
   e_t exp_q[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic       em, emdr, eir, epcw, ceq, cne, eao, ereg, eepc, iord, rdst, oa;
      logic [1:0] ob, m2r, opcw;
      logic [2:0] op;
      logic [5:0] st;
      uc_multiciclo_ws #(
         .MEM_WAIT(MWS[g*4 +: 4]),
         .STATE_W (6),
         .EXC_EN  (EES[g])
      ) u_dut (
         .clock          (clk),
         .reset          (rst_n[g]),
         .OPcode         (opc_in[g]),
         .funct          (fn_in[g]),
         .Overflow       (ovf_in[g]),
         .EscreveMem     (em),
         .EscreveMDR     (emdr),
         .EscreveIR      (eir),
         .EscrevePC      (epcw),
         .EscrevePCCondEQ(ceq),
         .EscrevePCCondNE(cne),
         .EscreveAluOut  (eao),
         .EscreveReg     (ereg),
         .EscreveEPC     (eepc),
         .IouD           (iord),
         .RegDst         (rdst),
         .OrigAALU       (oa),
         .OrigBALU       (ob),
         .OpAlu          (op),
         .MemparaReg     (m2r),
         .OrigPC         (opcw),
         .State          (st)
      );
      assign obs[g] = {st, em, emdr, eir, epcw, ceq, cne, eao, ereg, eepc,
                       iord, rdst, oa, ob, op, m2r, opcw};
   end

   function automatic int mw_of(input int g);
      return int'(MWS[g*4 +: 4]);
   endfunction

   function automatic bit ee_of(input int g);
      return EES[g];
   endfunction

   function automatic e_t blank(input int st);
      e_t e;
      e = '0;
      e.st = 6'(st);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic push_exc(input int st);
      e_t e;
      e = blank(st); e.epc = 1'b1; e.ob = 2'b01; e.op = 3'b001;
      exp_q.push_back(e);
      e = blank(st); e.opc = 2'b11; e.pc = 1'b1;
      exp_q.push_back(e);
   endtask

   // Expected per-cycle control trace of one instruction, starting at FETCH.
   task automatic model(input int g, input logic [5:0] op, input logic [5:0] fn, input logic ov);
      int mw;
      bit ee;
      e_t e;
      mw = mw_of(g);
      ee = ee_of(g);
      exp_q.delete();
      for (int i = 0; i <= mw; i++) begin
         e = blank(1);
         if (i == mw) begin e.ir = 1'b1; e.pc = 1'b1; e.ob = 2'b01; end
         exp_q.push_back(e);
      end
      e = blank(2); e.ob = 2'b11; e.aout = 1'b1;
      exp_q.push_back(e);
      case (op)
         6'h23, 6'h2B: begin
            e = blank(3); e.oa = 1'b1; e.ob = 2'b10; e.aout = 1'b1;
            exp_q.push_back(e);
            for (int i = 0; i <= mw; i++) begin
               if (op == 6'h23) begin
                  e = blank(4); e.iord = 1'b1; e.mdr = (i == mw);
               end else begin
                  e = blank(6); e.iord = 1'b1; e.mem = 1'b1;
               end
               exp_q.push_back(e);
            end
            if (op == 6'h23) begin
               e = blank(5); e.m2r = 2'b01; e.rw = 1'b1;
               exp_q.push_back(e);
            end
         end
         6'h00: begin
            e = blank(7); e.oa = 1'b1; e.op = 3'b010; e.aout = 1'b1;
            exp_q.push_back(e);
            if (ov && ee && (fn == 6'h20 || fn == 6'h22)) push_exc(15);
            else begin
               e = blank(8); e.rdst = 1'b1; e.rw = 1'b1;
               exp_q.push_back(e);
            end
         end
         6'h08: begin
            e = blank(9); e.oa = 1'b1; e.ob = 2'b10; e.aout = 1'b1;
            exp_q.push_back(e);
            if (ov && ee) push_exc(15);
            else begin
               e = blank(10); e.rw = 1'b1;
               exp_q.push_back(e);
            end
         end
         6'h04, 6'h05: begin
            e = blank(11); e.oa = 1'b1; e.op = 3'b001; e.opc = 2'b01;
            e.ceq = (op == 6'h04); e.cne = (op == 6'h05);
            exp_q.push_back(e);
         end
         6'h02: begin
            e = blank(12); e.opc = 2'b10; e.pc = 1'b1;
            exp_q.push_back(e);
         end
         6'h0F: begin
            e = blank(13); e.m2r = 2'b10; e.rw = 1'b1;
            exp_q.push_back(e);
         end
         default: if (ee) push_exc(14);
      endcase
   endtask

   // Entry and exit: at a negedge with DUT g in its first FETCH cycle.
   task automatic run_instr(input int g, input logic [5:0] op, input logic [5:0] fn,
                            input logic ov, output int cyc, output int n_epc,
                            output int n_rw, output int n_ceq, output int n_cne);
      bit seen;
      string tag;
      model(g, op, fn, ov);
      opc_in[g] = op;
      fn_in[g]  = fn;
      ovf_in[g] = ov;
      cyc = 0; n_epc = 0; n_rw = 0; n_ceq = 0; n_cne = 0; seen = 1'b0;
      tag = $sformatf("g%0d op%h fn%h ov%0d", g, op, fn, ov);
      for (int k = 0; k < 40; k++) begin
         if (seen && obs[g].st == 6'd1) break;
         if (obs[g].st != 6'd1) seen = 1'b1;
         if (cyc < exp_q.size())
            check($sformatf("trace %s c%0d", tag, cyc), obs[g], exp_q[cyc]);
         n_epc += int'(obs[g].epc);
         n_rw  += int'(obs[g].rw);
         n_ceq += int'(obs[g].ceq);
         n_cne += int'(obs[g].cne);
         cyc++;
         @(negedge clk);
      end
      check($sformatf("length %s", tag), 64'(cyc), 64'(exp_q.size()));
   endtask

   task automatic do_reset(input int g);
      rst_n = '0;
      @(negedge clk);
      check($sformatf("reset g%0d", g), obs[g], '0);
      rst_n[g] = 1'b1;
      @(negedge clk);
   endtask

   function automatic bit is_valid(input logic [5:0] op);
      return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0F, 6'h23, 6'h2B};
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[16];
      int cur_g;
      int cyc, n_epc, n_rw, n_ceq, n_cne, k;
      logic [5:0] ops[8];
      logic [5:0] fns[5];
      logic [5:0] rop, rfn;

      tbl[0]  = '{0, 6'h23, 6'h04, 1'b0, 9, 0, 1, 0, 0};
      tbl[1]  = '{0, 6'h00, 6'h20, 1'b1, 7, 1, 0, 0, 0};
      tbl[2]  = '{0, 6'h00, 6'h20, 1'b0, 6, 0, 1, 0, 0};
      tbl[3]  = '{0, 6'h00, 6'h24, 1'b1, 6, 0, 1, 0, 0};
      tbl[4]  = '{0, 6'h3F, 6'h00, 1'b0, 6, 1, 0, 0, 0};
      tbl[5]  = '{0, 6'h04, 6'h00, 1'b0, 5, 0, 0, 1, 0};
      tbl[6]  = '{0, 6'h05, 6'h00, 1'b0, 5, 0, 0, 0, 1};
      tbl[7]  = '{0, 6'h00, 6'h22, 1'b1, 7, 1, 0, 0, 0};
      tbl[8]  = '{1, 6'h0F, 6'h00, 1'b0, 3, 0, 1, 0, 0};
      tbl[9]  = '{1, 6'h08, 6'h00, 1'b0, 4, 0, 1, 0, 0};
      tbl[10] = '{1, 6'h02, 6'h00, 1'b0, 3, 0, 0, 0, 0};
      tbl[11] = '{1, 6'h2B, 6'h00, 1'b0, 4, 0, 0, 0, 0};
      tbl[12] = '{1, 6'h08, 6'h00, 1'b1, 5, 1, 0, 0, 0};
      tbl[13] = '{2, 6'h3F, 6'h00, 1'b0, 5, 0, 0, 0, 0};
      tbl[14] = '{2, 6'h08, 6'h00, 1'b1, 7, 0, 1, 0, 0};
      tbl[15] = '{2, 6'h2B, 6'h00, 1'b0, 10, 0, 0, 0, 0};

      cur_g = -1;
      @(negedge clk);
      foreach (tbl[i]) begin
         if (tbl[i].g != cur_g) begin
            cur_g = tbl[i].g;
            do_reset(cur_g);
         end
         run_instr(tbl[i].g, tbl[i].op, tbl[i].fn, tbl[i].ov, cyc, n_epc, n_rw, n_ceq, n_cne);
         check($sformatf("cycles v%0d", i), 64'(cyc), 64'(tbl[i].cyc));
         check($sformatf("epc v%0d", i), 64'(n_epc), 64'(tbl[i].epc));
         check($sformatf("regwr v%0d", i), 64'(n_rw), 64'(tbl[i].rw));
         check($sformatf("condeq v%0d", i), 64'(n_ceq), 64'(tbl[i].ceq));
         check($sformatf("condne v%0d", i), 64'(n_cne), 64'(tbl[i].cne));
      end

      // Reset asserted in the 2nd cycle of SW_WRITE, MEM_WAIT=3.
      do_reset(2);
      opc_in[2] = 6'h2B;
      k = 0;
      while (obs[2].st != 6'd6 && k < 20) begin @(negedge clk); k++; end
      check("sw reached", 64'(obs[2].st), 64'd6);
      @(negedge clk);
      check("sw 2nd cycle mem", 64'(obs[2].mem), 64'd1);
      rst_n[2] = 1'b0;
      @(negedge clk);
      check("sw abort state", 64'(obs[2].st), 64'd0);
      check("sw abort outputs", obs[2], '0);
      rst_n[2] = 1'b1;
      @(negedge clk);
      check("sw abort refetch", 64'(obs[2].st), 64'd1);

      // Reset during the first exception cycle: vector load must not happen.
      do_reset(0);
      opc_in[0] = 6'h3F;
      k = 0;
      while (obs[0].st != 6'd14 && k < 20) begin @(negedge clk); k++; end
      check("exc reached", 64'(obs[0].st), 64'd14);
      check("exc epc", 64'(obs[0].epc), 64'd1);
      rst_n[0] = 1'b0;
      @(negedge clk);
      check("exc abort outputs", obs[0], '0);
      rst_n[0] = 1'b1;
      @(negedge clk);

      // Randomized instruction streams per configuration.
      ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0F, 6'h23, 6'h2B};
      fns = '{6'h20, 6'h22, 6'h21, 6'h24, 6'h2A};
      for (int g = 0; g < 3; g++) begin
         do_reset(g);
         for (int n = 0; n < 40; n++) begin
            k = int'($urandom_range(0, 8));
            if (k == 8) begin
               rop = 6'($urandom);
               while (is_valid(rop)) rop = 6'($urandom);
            end else begin
               rop = ops[k];
            end
            rfn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(g, rop, rfn, 1'($urandom), cyc, n_epc, n_rw, n_ceq, n_cne);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
